// File: rtl/or16_skid_stage_pkg.sv
// Shared definitions for the OR16 skid stage: default widths and state encodings.
// Build option: OR16_SKID_MERGE_EN (see or16_skid_stage.sv).
package or16_skid_stage_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned COUNT_W_DEF = 4;

    // Encoding 2'd3 is unused; the stage recovers from it to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/or16_gate.sv
// Bitwise OR of two WIDTH-bit operands (combinational).
// Ports: a, b - operands; y_c - a | b.
module or16_gate
    import or16_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_c
);

    assign y_c = a | b;

endmodule

// File: rtl/or16_skid_stage.sv
// Registered valid/ready stage behind the 16-bit OR datapath with a 2-entry
// skid buffer (main + skid), a registered zero flag and optional beat merging.
// Build option: define OR16_SKID_MERGE_EN to OR-merge an in_merge beat into
// the pending main entry; otherwise in_merge is ignored and out_count is 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake (in_ready registered, = !FULL)
//   in_data, in_merge     upstream OR result and merge request
//   out_valid/out_ready   downstream handshake
//   out_data, out_zero    main entry data and its registered zero flag
//   out_count             beats folded into out_data minus 1 (saturating)
module or16_skid_stage
    import or16_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_W,
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_merge,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic [COUNT_W-1:0] out_count
);

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     skid_q;
    logic [WIDTH-1:0]     skid_d;
    logic [WIDTH-1:0]     main_d;
    logic [COUNT_W-1:0]   count_d;
    logic [WIDTH-1:0]     merged_c;
    logic [COUNT_W-1:0]   count_inc_c;
    logic                 merge_c;
    logic                 in_fire_c;
    logic                 out_fire_c;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // Merge datapath: main OR incoming beat.
    or16_gate #(.WIDTH(WIDTH)) u_merge_or (
        .a   (out_data),
        .b   (in_data),
        .y_c (merged_c)
    );

`ifdef OR16_SKID_MERGE_EN
    assign merge_c     = in_merge;
    assign count_inc_c = (out_count == '1) ? out_count : out_count + COUNT_W'(1);
`else
    logic unused_merge;
    assign unused_merge = ^{in_merge, merged_c};
    assign merge_c      = 1'b0;
    assign count_inc_c  = '0;
`endif

    // Next-state and next-entry logic.
    always_comb begin
        state_d = state_q;
        main_d  = out_data;
        skid_d  = skid_q;
        count_d = out_count;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_c) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                    count_d = '0;
                end
            end
            ST_ONE: begin
                if (in_fire_c && out_fire_c) begin
                    main_d  = in_data;
                    count_d = '0;
                end else if (in_fire_c && merge_c) begin
                    main_d  = merged_c;
                    count_d = count_inc_c;
                end else if (in_fire_c) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_fire_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Skid entries are never merged, so they always carry count 0.
                if (out_fire_c) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
                count_d = '0;
            end
        endcase
    end

    // State, entries and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_data  <= '0;
            skid_q    <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_zero  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_data  <= main_d;
            skid_q    <= skid_d;
            out_count <= count_d;
            out_valid <= (state_d == ST_ONE) || (state_d == ST_FULL);
            in_ready  <= (state_d != ST_FULL);
            out_zero  <= ((state_d == ST_ONE) || (state_d == ST_FULL)) && (main_d == '0);
        end
    end

endmodule

// File: tb/tb_or16_skid_stage.sv
// Scoreboard bench for or16_skid_stage: the stage is modelled as a queue of
// pending beats (at most two); a monitor compares the DUT against its head.
module tb_or16_skid_stage;

`ifdef OR16_SKID_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        int          count;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_merge;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic [3:0]  out_count;

    beat_t sbq[$];
    int    snap_size;
    int    checks;
    int    errors;

    or16_skid_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_merge  (in_merge),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT against the model between clock edges.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(sbq.size() < 2));
            check("out_valid", 32'(out_valid), 32'(sbq.size() > 0));
            if (sbq.size() > 0) begin
                check("out_data", 32'(out_data), 32'(sbq[0].data));
                check("out_zero", 32'(out_zero), 32'(sbq[0].data == 16'h0));
                check("out_count", 32'(out_count), 32'(sbq[0].count));
            end else begin
                check("out_zero_idle", 32'(out_zero), 32'h0);
            end
            snap_size = sbq.size();
        end
    end

    // Monitor pop: the head leaves when downstream accepts it.
    always @(posedge clk) begin
        if (rst_n && snap_size > 0 && out_ready)
            void'(sbq.pop_front());
    end

    // Scoreboard push: accepted beats join the queue or fold into the lone pending beat.
    always @(posedge clk) begin
        if (rst_n && in_valid && snap_size < 2) begin
            if (MERGE_EN && in_merge && snap_size == 1 && !out_ready) begin
                sbq[0].data  = sbq[0].data | in_data;
                sbq[0].count = (sbq[0].count >= 15) ? 15 : sbq[0].count + 1;
            end else begin
                sbq.push_back('{data: in_data, count: 0});
            end
        end
    end

    // Present one beat starting at a negedge; returns at the negedge after it is taken.
    task automatic send(input logic [15:0] d, input logic m);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_merge = m;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(in_ready), 32'h1);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_merge = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sbq.size()), 32'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        snap_size = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_merge  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Stream at full throughput.
        out_ready = 1'b1;
        send(16'h00F0, 1'b0);
        send(16'h0F00, 1'b0);
        send(16'hF000, 1'b0);
        drain();

        // Back-pressure, then release.
        out_ready = 1'b0;
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        drain();

        // Zero flag.
        out_ready = 1'b0;
        send(16'h0000, 1'b0);
        idle();
        @(negedge clk);
        check("zero_flag_set", 32'(out_zero), 32'h1);
        drain();
        out_ready = 1'b0;
        send(16'h8000, 1'b0);
        idle();
        @(negedge clk);
        check("zero_flag_clear", 32'(out_zero), 32'h0);
        drain();

        // Merge request under back-pressure.
        out_ready = 1'b0;
        send(16'h0001, 1'b0);
        send(16'h0100, 1'b1);
        idle();
        @(negedge clk);
        if (MERGE_EN) begin
            check("merge_data", 32'(out_data), 32'h0101);
            check("merge_count", 32'(out_count), 32'h1);
            for (int i = 0; i < 17; i++)
                send(16'(1) << (i % 16), 1'b1);
            idle();
            @(negedge clk);
            check("merge_sat", 32'(out_count), 32'hF);
        end else begin
            check("nomerge_full", 32'(in_ready), 32'h0);
            check("nomerge_count", 32'(out_count), 32'h0);
        end
        drain();

        // Reset while FULL.
        out_ready = 1'b0;
        send(16'hAAAA, 1'b0);
        send(16'h5555, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        sbq.delete();
        snap_size = 0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_zero", 32'(out_zero), 32'h0);
        check("rst_out_count", 32'(out_count), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Randomised traffic checked by the monitor.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_merge  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       in_data = 16'h0000;
                1:       in_data = 16'(1) << $urandom_range(0, 15);
                default: in_data = 16'($urandom);
            endcase
            @(negedge clk);
        end
        drain();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
